// File: rtl/point_add_arbiter.sv
// Round-robin arbiter sharing one PointAdd datapath between NUM_REQ requesters.
// Operands are registered at grant; a 12-bit watchdog aborts hung operations.
module point_add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 255,
  parameter int TIMEOUT = 4095
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_x1,
  input  logic [NUM_REQ*WIDTH-1:0] i_y1,
  input  logic [NUM_REQ*WIDTH-1:0] i_z1,
  input  logic [NUM_REQ*WIDTH-1:0] i_x2,
  input  logic [NUM_REQ*WIDTH-1:0] i_y2,
  input  logic [NUM_REQ*WIDTH-1:0] i_z2,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_timeout,
  output logic                     o_busy,
  output logic [WIDTH-1:0]         o_x3,
  output logic [WIDTH-1:0]         o_y3,
  output logic [WIDTH-1:0]         o_z3,
  output logic                     o_pa_start,
  output logic [WIDTH-1:0]         o_pa_x1,
  output logic [WIDTH-1:0]         o_pa_y1,
  output logic [WIDTH-1:0]         o_pa_z1,
  output logic [WIDTH-1:0]         o_pa_x2,
  output logic [WIDTH-1:0]         o_pa_y2,
  output logic [WIDTH-1:0]         o_pa_z2,
  input  logic                     i_pa_finished,
  input  logic [WIDTH-1:0]         i_pa_x3,
  input  logic [WIDTH-1:0]         i_pa_y3,
  input  logic [WIDTH-1:0]         i_pa_z3
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_LAUNCH, S_BUSY, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [11:0]       wd_q, wd_d;
  logic              to_q, to_d;
  logic [WIDTH-1:0]  x1_q, y1_q, z1_q, x2_q, y2_q, z2_q;
  logic [WIDTH-1:0]  x1_d, y1_d, z1_d, x2_d, y2_d, z2_d;
  logic [WIDTH-1:0]  x3_q, y3_q, z3_q, x3_d, y3_d, z3_d;
  logic [IW-1:0]     pick;
  logic              found;
  logic [IW:0]       sum;

  // First requester at or after the rr pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      if (!found && i_req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      z1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      z2_q    <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      z3_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      z1_q    <= z1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      z2_q    <= z2_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      z3_q    <= z3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    to_d    = to_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    z1_d    = z1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    z2_d    = z2_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    z3_d    = z3_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LAUNCH;
          owner_d = pick;
          x1_d    = i_x1[int'(pick)*WIDTH +: WIDTH];
          y1_d    = i_y1[int'(pick)*WIDTH +: WIDTH];
          z1_d    = i_z1[int'(pick)*WIDTH +: WIDTH];
          x2_d    = i_x2[int'(pick)*WIDTH +: WIDTH];
          y2_d    = i_y2[int'(pick)*WIDTH +: WIDTH];
          z2_d    = i_z2[int'(pick)*WIDTH +: WIDTH];
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        to_d    = 1'b0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        wd_d = wd_q + 12'd1;
        // A completion in the watchdog's final cycle still counts.
        if (i_pa_finished) begin
          x3_d    = i_pa_x3;
          y3_d    = i_pa_y3;
          z3_d    = i_pa_z3;
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        to_d    = 1'b0;
        rr_d    = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_grant    = '0;
    o_done     = '0;
    o_pa_start = 1'b0;
    o_timeout  = 1'b0;
    o_busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_LAUNCH: begin
        o_grant[owner_q] = 1'b1;
        o_pa_start       = 1'b1;
      end
      S_DONE: begin
        o_done[owner_q] = 1'b1;
        o_timeout       = to_q;
      end
      default: ;
    endcase
  end

  assign o_x3    = x3_q;
  assign o_y3    = y3_q;
  assign o_z3    = z3_q;
  assign o_pa_x1 = x1_q;
  assign o_pa_y1 = y1_q;
  assign o_pa_z1 = z1_q;
  assign o_pa_x2 = x2_q;
  assign o_pa_y2 = y2_q;
  assign o_pa_z2 = z2_q;

endmodule
